// File: rtl/mcu_periph_uart.sv
// mcu_periph_uart: memory-mapped 8N1 UART on the MCU peripheral bus.
//   Registers (mem_addr[3:2]): 0 DATA, 1 STATUS, 2 CLKDIV, 3 reserved.
//   TX path goes through a TX_FIFO_DEPTH-entry FIFO. RX path has a
//   single-byte holding register with sticky error flags.
// Ports:
//   sys_clk, rst         clock, synchronous active-high reset
//   mem_valid/mem_ready  valid/ready handshake, ready fixed 1 cycle after valid
//   mem_addr/mem_wdata/mem_wstrb/mem_rdata  native bus, wstrb==0 is a read
//   uart_tx/uart_rx      serial line (uart_rx is asynchronous)
//   irq_rx               level interrupt, equals rx_valid
module mcu_periph_uart #(
  parameter logic [15:0] DIV_RESET     = 16'd434,
  parameter int          TX_FIFO_DEPTH = 8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq_rx
);
  localparam int AW = $clog2(TX_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  typedef struct packed {
    logic tx_overflow;
    logic rx_frame_err;
    logic rx_overrun;
    logic rx_valid;
    logic tx_busy;
    logic tx_empty;
    logic tx_full;
  } status_t;

  // ---------------------------------------------------------------- bus decode
  logic       acc, wr, rd;
  logic [1:0] reg_sel;
  logic       rd_data, w1c;

  // acc is the single cycle in which a transaction takes effect
  assign acc     = mem_valid & ~mem_ready;
  assign wr      = acc & (|mem_wstrb);
  assign rd      = acc & ~(|mem_wstrb);
  assign reg_sel = mem_addr[3:2];
  assign rd_data = rd && (reg_sel == 2'd0);
  assign w1c     = wr && (reg_sel == 2'd1) && mem_wstrb[0];

  logic unused_bits;
  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

  // ---------------------------------------------------------------- clock divider
  logic [15:0] clkdiv, per, half;
  assign per  = (clkdiv < 16'd4) ? 16'd4 : clkdiv;
  assign half = per >> 1;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]  fifo [TX_FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, empty, push_req, push, pop;
  state_t      tx_st;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_req = wr && (reg_sel == 2'd0) && mem_wstrb[0];
  assign pop      = (tx_st == S_IDLE) && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign push     = push_req && (!full || pop);

  always_ff @(posedge sys_clk) begin
    if (push) fifo[wptr[AW-1:0]] <= mem_wdata[7:0];
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  // Bit counters reload from per at every bit boundary, so a CLKDIV
  // change lands on the next bit.
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tx_st   <= S_IDLE;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (tx_st)
        S_IDLE: if (pop) begin
          tx_sh   <= fifo[rptr[AW-1:0]];
          tx_cnt  <= per - 16'd1;
          uart_tx <= 1'b0;
          tx_st   <= S_START;
        end
        S_START: if (tx_cnt == '0) begin
          uart_tx <= tx_sh[0];
          tx_sh   <= tx_sh >> 1;
          tx_bit  <= '0;
          tx_cnt  <= per - 16'd1;
          tx_st   <= S_DATA;
        end else tx_cnt <= tx_cnt - 16'd1;
        S_DATA: if (tx_cnt == '0) begin
          tx_cnt <= per - 16'd1;
          if (tx_bit == 3'd7) begin
            uart_tx <= 1'b1;
            tx_st   <= S_STOP;
          end else begin
            uart_tx <= tx_sh[0];
            tx_sh   <= tx_sh >> 1;
            tx_bit  <= tx_bit + 3'd1;
          end
        end else tx_cnt <= tx_cnt - 16'd1;
        S_STOP: if (tx_cnt == '0) tx_st <= S_IDLE;
                else tx_cnt <= tx_cnt - 16'd1;
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FSM
  // rx_s1/rx_s2 synchronise; rx_s3 is the previous synchronised value for
  // falling-edge detection. Sampling happens at mid-bit (half period after
  // the edge, then whole periods).
  logic        rx_s1, rx_s2, rx_s3;
  state_t      rx_st;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_stop_now, rx_ok, rx_ferr;

  assign rx_stop_now = (rx_st == S_STOP) && (rx_cnt == '0);
  assign rx_ok       = rx_stop_now & rx_s2;
  assign rx_ferr     = rx_stop_now & ~rx_s2;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_s3  <= 1'b1;
      rx_st  <= S_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_st)
        S_IDLE: if (rx_s3 && !rx_s2) begin
          rx_cnt <= half - 16'd1;
          rx_st  <= S_START;
        end
        S_START: if (rx_cnt == '0) begin
          if (rx_s2) rx_st <= S_IDLE;   // glitch, not a start bit
          else begin
            rx_cnt <= per - 16'd1;
            rx_bit <= '0;
            rx_st  <= S_DATA;
          end
        end else rx_cnt <= rx_cnt - 16'd1;
        S_DATA: if (rx_cnt == '0) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_cnt <= per - 16'd1;
          if (rx_bit == 3'd7) rx_st <= S_STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt - 16'd1;
        S_STOP: if (rx_cnt == '0) rx_st <= S_IDLE;
                else rx_cnt <= rx_cnt - 16'd1;
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- flags
  // Set events take priority over clears in the same cycle.
  logic [7:0] rx_byte;
  logic       rx_valid, rx_overrun, rx_frame_err, tx_overflow, rx_load;

  assign rx_load = rx_ok && (!rx_valid || rd_data);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      if (rx_load) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rd_data) rx_valid <= 1'b0;

      if (rx_ok && rx_valid && !rd_data) rx_overrun <= 1'b1;
      else if (w1c && mem_wdata[4])      rx_overrun <= 1'b0;

      if (rx_ferr)                  rx_frame_err <= 1'b1;
      else if (w1c && mem_wdata[5]) rx_frame_err <= 1'b0;

      if (push_req && !push)        tx_overflow <= 1'b1;
      else if (w1c && mem_wdata[6]) tx_overflow <= 1'b0;
    end
  end

  assign irq_rx = rx_valid;

  // ---------------------------------------------------------------- registers
  status_t     status;
  logic [31:0] rdata_nxt;

  assign status = '{tx_overflow: tx_overflow, rx_frame_err: rx_frame_err,
                    rx_overrun: rx_overrun, rx_valid: rx_valid,
                    tx_busy: (tx_st != S_IDLE), tx_empty: empty, tx_full: full};

  always_comb begin
    rdata_nxt = '0;
    case (reg_sel)
      2'd0:    rdata_nxt = {23'd0, rx_valid, rx_byte};
      2'd1:    rdata_nxt = {25'd0, status};
      2'd2:    rdata_nxt = {16'd0, clkdiv};
      default: rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      clkdiv    <= DIV_RESET;
    end else begin
      mem_ready <= acc;
      mem_rdata <= rd ? rdata_nxt : 32'd0;
      if (wr && (reg_sel == 2'd2)) begin
        if (mem_wstrb[0]) clkdiv[7:0]  <= mem_wdata[7:0];
        if (mem_wstrb[1]) clkdiv[15:8] <= mem_wdata[15:8];
      end
    end
  end

endmodule

// File: doc/mcu_periph_uart.md
Name: mcu_periph_uart

Overview:
- Memory-mapped 8N1 UART on the MCU subsystem peripheral bus; sits directly downstream of the subsystem's periph_mem_* port and is the first peripheral on that bus.
- TX path: FIFO-buffered. RX path: single-byte holding register with status flags. Baud rate is programmable through a clock divider register.
- Uses the same valid/ready native bus protocol as the CPU bus. Port-level address decode is done upstream; this block decodes only mem_addr[3:2].

Parameters:
- DIV_RESET, 16'd434, reset value of CLKDIV in sys_clk cycles per bit (50 MHz / 115200).
- TX_FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_valid  input  1  bus request; held high until mem_ready is sampled.
- mem_ready  output  1  one-cycle transaction acknowledge.
- mem_addr  input  32  byte address; only bits [3:2] decoded.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte-lane write enables; 4'b0000 means read.
- mem_rdata  output  32  read data, valid while mem_ready = 1.
- uart_tx  output  1  serial out, idle high.
- uart_rx  input  1  serial in, asynchronous.
- irq_rx  output  1  level interrupt, equals rx_valid.

Behaviour:
- Reset (one cycle is sufficient; applies mid-frame too):
  - uart_tx = 1, mem_ready = 0, mem_rdata = 0, irq_rx = 0.
  - TX FIFO empty; TX and RX FSMs in IDLE.
  - CLKDIV = DIV_RESET; all sticky flags = 0.
  - Any frame in progress is abandoned; uart_tx is high on the cycle after rst is sampled.
- Bus handshake:
  - mem_ready <= mem_valid & ~mem_ready, so ready is high exactly in the cycle after valid is first sampled: fixed 1-cycle latency.
  - Never two consecutive ready cycles. Register side effects occur once, on the cycle ready is driven high.
  - mem_rdata is registered alongside ready and returns to 0 when ready is low.
- Register map (by addr[3:2]):
  - 0 DATA, write: if wstrb[0], push wdata[7:0] to the TX FIFO. If the FIFO is full, the byte is dropped and tx_overflow is set.
  - 0 DATA, read: rdata[7:0] = rx_byte, rdata[8] = rx_valid. The read clears rx_valid.
  - 1 STATUS, read: bit0 tx_full, bit1 tx_empty, bit2 tx_busy (FSM not IDLE), bit3 rx_valid, bit4 rx_overrun, bit5 rx_frame_err, bit6 tx_overflow.
  - 1 STATUS, write: bits 4..6 are write-1-to-clear, applied when wstrb[0] = 1.
  - 2 CLKDIV: 16-bit value, written per byte lanes 0/1. Effective bit period = max(CLKDIV, 4) cycles.
  - 3: reserved; reads 0, writes ignored.
- TX FSM (IDLE -> START -> DATA -> STOP -> IDLE):
  - Pops the FIFO in IDLE when it is not empty; the start bit drives on the next cycle.
  - Each bit lasts exactly the bit period; data is sent LSB first, 8 bits, then one stop bit (high).
  - Back-to-back bytes: no idle gap beyond one cycle.
  - A CLKDIV change mid-frame takes effect at the next bit boundary.
- RX FSM (IDLE -> START -> DATA -> STOP):
  - uart_rx passes through a 2-flop synchroniser; a falling edge in IDLE starts reception.
  - Waits half a bit period and re-samples. If the line is high, the event is a glitch and the FSM returns to IDLE.
  - Samples 8 data bits at mid-bit, then the stop bit.
  - Stop bit = 0: set rx_frame_err, discard the byte.
  - Stop bit = 1 and rx_valid already set: set rx_overrun, discard the new byte, keep the old one.
  - Otherwise: load rx_byte and set rx_valid.
- Simultaneous events:
  - DATA read clearing rx_valid in the same cycle a new byte completes: the new byte loads, rx_valid stays 1, no overrun.
  - W1C clear in the same cycle as a flag-set event: the set wins.
  - FIFO push and pop in the same cycle with the FIFO full: the pop frees a slot, so the push is accepted (no overflow).
  - FIFO pointers wrap modulo TX_FIFO_DEPTH; full/empty are derived using an extra pointer bit.

Test Plan:
- Reset, then read STATUS and CLKDIV -> STATUS = 0x02, CLKDIV = 434; uart_tx = 1; each mem_ready pulse is exactly 1 cycle, 1 cycle after valid.
- Write CLKDIV = 8, then write DATA 0xA5 -> uart_tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each exactly 8 cycles; tx_busy = 1 during the frame, 0 after.
- Write 9 bytes back-to-back while the first is being transmitted (depth 8) -> all 9 transmitted in order, tx_overflow = 0; then 10 writes with uart idle blocked by CLKDIV = 0xFFFF -> the 10th is dropped, STATUS bit6 = 1; write 0x40 to STATUS -> bit6 = 0.
- Drive 0x3C on uart_rx at CLKDIV = 16 -> irq_rx = 1; DATA read returns 0x13C, then a second read returns 0x03C with rx_valid = 0; a 3-cycle low glitch on uart_rx produces no byte.
- Send two bytes without reading -> the first byte is retained, rx_overrun = 1; a frame with stop bit = 0 -> rx_frame_err = 1, rx_valid unchanged.
- Assert rst mid TX frame and mid RX frame -> uart_tx high on the next cycle, FIFO empty, no rx_valid set, CLKDIV = 434.
